// File: rtl/panda_lsu.sv
// panda_lsu: load/store unit issuing one req/gnt/rvalid transaction per accepted op
module panda_lsu #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic [Width-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             misaligned_o,
  output logic [Width-1:0] rdata_o,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  output logic [Width-1:0] data_addr_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [Width-1:0] data_wdata_o,
  input  logic             data_rvalid_i,
  input  logic [Width-1:0] data_rdata_i
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;
  state_t state, state_next;
  logic we_q, uns_q, valid_q, mis_q;
  logic [1:0] size_q;
  logic [Width-1:0] addr_q, wdata_q, rdata_q, shifted, load_data;
  logic [3:0] be;
  logic accept, misaligned, done;
  assign accept = state == IDLE && req_i;
  assign misaligned = size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) || (size_i == 2'b10 && addr_i[1:0] != 2'b00);
  assign done = state == WAIT_RVALID && data_rvalid_i;
  // State register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_next;
  // Next-state: rejected accesses never leave IDLE; rvalid only counts after the grant
  always_comb begin
    state_next = accept && !misaligned ? WAIT_GNT :
                 state == WAIT_GNT && data_gnt_i ? WAIT_RVALID :
                 done ? IDLE : state;
  end
  // Operation capture and registered completion/rejection pulses
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      valid_q <= done;
      mis_q   <= accept && misaligned;
      if (done && !we_q) rdata_q <= load_data;
    end
  // Lane alignment of the read word and byte-enable formation
  always_comb begin
    shifted   = data_rdata_i >> {addr_q[1:0], 3'b000};
    load_data = size_q == 2'b00 ? {{(Width-8){shifted[7] & ~uns_q}}, shifted[7:0]} :
                size_q == 2'b01 ? {{(Width-16){shifted[15] & ~uns_q}}, shifted[15:0]} : shifted;
    be        = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                size_q == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
  end
  // Outputs: bus fields only driven while requesting, so idle/reset leaves them 0
  always_comb begin
    busy_o       = state != IDLE;
    data_req_o   = state == WAIT_GNT;
    data_addr_o  = data_req_o ? {addr_q[Width-1:2], 2'b00} : '0;
    data_we_o    = data_req_o && we_q;
    data_be_o    = data_req_o ? be : 4'b0000;
    data_wdata_o = !data_req_o ? '0 :
                   size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                   size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    valid_o      = valid_q;
    misaligned_o = mis_q;
    rdata_o      = rdata_q;
  end
endmodule

// File: tb/tb_panda_lsu.sv
// tb_panda_lsu: directed and randomized checks of panda_lsu against a behavioural model
module tb_panda_lsu;
  logic clk = 0, rst_ni = 0, req_i = 0, we_i = 0, unsigned_i = 0;
  logic data_gnt_i = 0, data_rvalid_i = 0;
  logic [1:0] size_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, data_rdata_i = 0;
  logic busy_o, valid_o, misaligned_o, data_req_o, data_we_o;
  logic [3:0] data_be_o;
  logic [31:0] rdata_o, data_addr_o, data_wdata_o;
  int checks = 0, errors = 0;
  logic [31:0] model_rdata = 0;

  panda_lsu #(.Width(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .valid_o(valid_o), .misaligned_o(misaligned_o), .rdata_o(rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] size, input int off);
    return size == 3 || (size == 1 && off % 2 != 0) || (size == 2 && off != 0);
  endfunction

  function automatic logic [31:0] exp_be(input logic [1:0] size, input int off);
    return size == 0 ? 32'(1 << off) : size == 1 ? 32'(3 << (off & 2)) : 32'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] w);
    return size == 0 ? (w % 256) * 32'h01010101 : size == 1 ? (w % 65536) * 32'h00010001 : w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns, input int off, input logic [31:0] raw);
    logic [31:0] v;
    v = raw >> (8 * off);
    if (size == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge where valid_o/misaligned_o is expected
  task automatic op(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [31:0] raw, input int gd, input int rd, input bit poke);
    int off;
    off = int'(addr[1:0]);
    req_i = 1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    @(negedge clk);
    req_i = 0; we_i = 1'($urandom); size_i = 2'($urandom); unsigned_i = 1'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
    if (is_mis(size, off)) begin
      chk("mis_pulse", 32'(misaligned_o), 1);
      chk("mis_busy", 32'(busy_o), 0);
      chk("mis_req", 32'(data_req_o), 0);
      chk("mis_valid", 32'(valid_o), 0);
      return;
    end
    chk("no_mis", 32'(misaligned_o), 0);
    for (int d = 0; d <= gd; d++) begin
      chk("req", 32'(data_req_o), 1);
      chk("addr", data_addr_o, addr & 32'hFFFF_FFFC);
      chk("we", 32'(data_we_o), 32'(we));
      chk("be", 32'(data_be_o), exp_be(size, off));
      chk("wdata", data_wdata_o, exp_wdata(size, wdata));
      chk("busy_gnt", 32'(busy_o), 1);
      chk("valid_early", 32'(valid_o), 0);
      req_i = poke; data_gnt_i = (d == gd);
      @(negedge clk);
    end
    data_gnt_i = 0;
    for (int d = 0; d <= rd; d++) begin
      chk("req_after_gnt", 32'(data_req_o), 0);
      chk("busy_rv", 32'(busy_o), 1);
      chk("valid_wait", 32'(valid_o), 0);
      data_rvalid_i = (d == rd); data_rdata_i = (d == rd) ? raw : $urandom;
      @(negedge clk);
    end
    data_rvalid_i = 0; req_i = 0;
    if (!we) model_rdata = exp_load(size, uns, off, raw);
    chk("valid", 32'(valid_o), 1);
    chk("rdata", rdata_o, model_rdata);
    chk("busy_done", 32'(busy_o), 0);
  endtask

  task automatic idle();
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_req", 32'(data_req_o), 0);
    chk("idle_mis", 32'(misaligned_o), 0);
    chk("idle_valid", 32'(valid_o), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_req", 32'(data_req_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_mis", 32'(misaligned_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_be", 32'(data_be_o), 0);
    chk("rst_addr", data_addr_o, 0);
    rst_ni = 1;
    @(negedge clk);
    op(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
    chk("lw_value", rdata_o, 32'hDEADBEEF);
    op(0, 0, 0, 32'h103, 0, 32'h80000000, 0, 0, 0);
    chk("lb_value", rdata_o, 32'hFFFFFF80);
    op(0, 0, 1, 32'h103, 0, 32'h80000000, 0, 0, 0);
    chk("lbu_value", rdata_o, 32'h00000080);
    op(0, 1, 1, 32'h102, 0, 32'hBEEF0000, 0, 0, 0);
    chk("lhu_value", rdata_o, 32'h0000BEEF);
    op(1, 1, 0, 32'h102, 32'h1234ABCD, 32'h55555555, 3, 0, 0);
    chk("sh_keeps_rdata", rdata_o, 32'h0000BEEF);
    idle();
    op(0, 2, 0, 32'h101, 0, 0, 0, 0, 0);
    idle();
    op(0, 1, 0, 32'h203, 0, 0, 0, 0, 0);
    idle();
    op(0, 3, 0, 32'h200, 0, 0, 0, 0, 0);
    idle();
    op(0, 2, 0, 32'h400, 0, 32'hCAFEF00D, 2, 1, 1);
    idle();
    op(0, 2, 0, 32'h500, 0, 32'h01234567, 0, 0, 0);
    op(1, 2, 0, 32'h504, 32'h89ABCDEF, 0, 0, 0, 0);
    idle();
    req_i = 1; we_i = 0; size_i = 2; addr_i = 32'h300;
    @(negedge clk);
    req_i = 0; data_gnt_i = 1;
    @(negedge clk);
    data_gnt_i = 0;
    chk("pre_rst_busy", 32'(busy_o), 1);
    rst_ni = 0;
    #1;
    model_rdata = 0;
    chk("async_busy", 32'(busy_o), 0);
    chk("async_req", 32'(data_req_o), 0);
    chk("async_rdata", rdata_o, 0);
    chk("async_valid", 32'(valid_o), 0);
    @(negedge clk);
    rst_ni = 1; data_rvalid_i = 1; data_rdata_i = 32'h77777777;
    @(negedge clk);
    data_rvalid_i = 0;
    chk("stray_valid", 32'(valid_o), 0);
    chk("stray_rdata", rdata_o, 0);
    chk("stray_busy", 32'(busy_o), 0);
    for (int i = 0; i < 80; i++) begin
      op(1'($urandom), 2'($urandom), 1'($urandom), $urandom & 32'hFFFF, $urandom, $urandom,
         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
